signed_mult_seq: RTL and testbench
==================================

# signed_mult_seq

Parametrised sequential signed (two's-complement) shift-add multiplier built around a WIDTH+1-bit add/subtract datapath: it generalises the fixed 8-bit add/sub to any operand width and adds the control, register and shift logic. It sits between the switch/register front end and the hex display path, and replaces ad-hoc add/sub plus top-level sequencing. The block takes WIDTH-bit operands with a start/done handshake and produces a 2·WIDTH-bit product.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32
- Clk  input  1  system clock; all state changes on rising edge
- Reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- multiplicand  input  WIDTH  signed S operand, latched on accepted start
- multiplier  input  WIDTH  signed B operand, latched on accepted start
- busy  output  1  high in ADD and SHIFT states
- done  output  1  one-cycle pulse when product becomes valid
- product  output  2·WIDTH  {A,B} register pair; signed result after done
- x_sign  output  1  X flip-flop (sign extension bit of A)

## Operation
- Registers: S (WIDTH), A (WIDTH), B (WIDTH), X (1), cnt ($clog2(WIDTH+1) bits).
- States: IDLE, ADD, SHIFT, DONE.
- IDLE: start=1 → S←multiplicand, B←multiplier, A←0, X←0, cnt←0, go to ADD. start=0 → stay; A, B, X hold.
- ADD: if B[0]=1: {X,A} ← sign-extended A ± sign-extended S, computed at WIDTH+1 bits. The operation is subtract when cnt=WIDTH-1 and add otherwise. If B[0]=0, A and X hold. Always go to SHIFT.
- SHIFT: {X,A,B} arithmetic shift right by 1: X keeps its value, A[WIDTH-1]←X, B[WIDTH-1]←A[0]. Then cnt←cnt+1. If the new cnt equals WIDTH, go to DONE; otherwise go to ADD.
- DONE: done=1, then go to IDLE. product holds until the next accepted start.
- start while busy or in DONE is ignored; operands are not resampled.
- Arithmetic: add/sub carry-out is discarded; X is bit WIDTH of the WIDTH+1-bit sum. Full range is exact, including −2^(WIDTH−1) × −2^(WIDTH−1) = +2^(2·WIDTH−2).
- Reset (any state, including mid-operation): state←IDLE; A, B, S, X, cnt←0; busy=0, done=0, product=0, x_sign=0. A partial result is discarded.

## Timing
- Reset values: busy=0, done=0, product=0, x_sign=0.
- If start is sampled high in IDLE at edge t, busy is high from edge t+1 to edge t+2·WIDTH.
- done is high for exactly the cycle after edge t+2·WIDTH. Latency is 2·WIDTH+1 edges from acceptance to done.
- The earliest next accepted start is at edge t+2·WIDTH+2 (in IDLE). start held high continuously restarts immediately after each DONE.
- product and x_sign are registered outputs that change only on edges. Intermediate values are visible while busy.
- Reset asserted on the same edge as an accepted start: reset wins, and the operation is not started.

## Configuration
- SMULT_SKIP_ZERO_EN defined: the ADD state is skipped when B[0]=0. SHIFT goes directly to SHIFT for the next bit, and IDLE goes to SHIFT on start when multiplier[0]=0.
  - Latency becomes WIDTH + popcount(multiplier) + 1 edges to done.
  - The result is identical.
- Undefined: fixed 2·WIDTH+1 latency as specified in Timing.

## Test plan
- WIDTH=8: multiplicand=7, multiplier=−3 (8'hFD), start 1 cycle → done exactly 17 edges later; product=16'hFFEB, x_sign=1.
- WIDTH=8: −128 × −128 → product=16'h4000; 127 × 127 → 16'h3F01; −1 × −1 → 16'h0001; 0 × −128 → 16'h0000.
- WIDTH=8, start held high, operands changed while busy → first product uses the operands latched at the first acceptance. The next operation starts the cycle after DONE.
- WIDTH=8, assert Reset during SHIFT of bit 3 → next cycle: busy=0, product=0, no done pulse. A fresh 5 × 5 then gives 16'h0019.
- WIDTH=16: 16'h8000 × 16'h7FFF → product=32'hC0008000; done 33 edges after start.
- Build with SMULT_SKIP_ZERO_EN, WIDTH=8: 3 × 8'h01 → product=16'h0003, done 10 edges after start. Without the macro, the same case takes 17 edges.

Source files
------------

// File: rtl/signed_mult_seq.sv
// Sequential two's-complement shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH product.
// Optional build macro SMULT_SKIP_ZERO_EN skips the ADD state for zero multiplier bits.
module signed_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   start,
    input  logic [WIDTH-1:0]       multiplicand,
    input  logic [WIDTH-1:0]       multiplier,
    output logic                   busy,
    output logic                   done,
    output logic [2*WIDTH-1:0]     product,
    output logic                   x_sign
);

    // state | meaning
    // IDLE  | waiting for start; product holds last result
    // ADD   | conditionally accumulate S into {X,A} (subtract on the sign bit)
    // SHIFT | arithmetic shift of {X,A,B}, advance bit counter
    // DONE  | one-cycle done pulse, then back to IDLE
    typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_END  = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] s_reg, s_nxt;
    logic [WIDTH-1:0] a_reg, a_nxt;
    logic [WIDTH-1:0] b_reg, b_nxt;
    logic             x_reg, x_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;

    logic [WIDTH:0]   a_ext, s_ext, sum;
    logic             sub;

    // The multiplier's sign bit carries weight -2^(WIDTH-1), hence the final subtract.
    assign a_ext = {a_reg[WIDTH-1], a_reg};
    assign s_ext = {s_reg[WIDTH-1], s_reg};
    assign sub   = (cnt == CNT_LAST);
    assign sum   = sub ? (a_ext - s_ext) : (a_ext + s_ext);

    always_comb begin
        state_nxt = state;
        s_nxt     = s_reg;
        a_nxt     = a_reg;
        b_nxt     = b_reg;
        x_nxt     = x_reg;
        cnt_nxt   = cnt;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    s_nxt   = multiplicand;
                    b_nxt   = multiplier;
                    a_nxt   = '0;
                    x_nxt   = 1'b0;
                    cnt_nxt = '0;
`ifdef SMULT_SKIP_ZERO_EN
                    state_nxt = multiplier[0] ? ADD : SHIFT;
`else
                    state_nxt = ADD;
`endif
                end
            end
            ADD: begin
                busy = 1'b1;
                if (b_reg[0]) begin
                    {x_nxt, a_nxt} = sum;
                end
                state_nxt = SHIFT;
            end
            SHIFT: begin
                busy    = 1'b1;
                a_nxt   = {x_reg, a_reg[WIDTH-1:1]};
                b_nxt   = {a_reg[0], b_reg[WIDTH-1:1]};
                cnt_nxt = cnt + CNT_ONE;
                if (cnt_nxt == CNT_END) begin
                    state_nxt = DONE;
                end else begin
`ifdef SMULT_SKIP_ZERO_EN
                    // b_reg[1] becomes the next B[0] after this shift
                    state_nxt = b_reg[1] ? ADD : SHIFT;
`else
                    state_nxt = ADD;
`endif
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            s_reg <= '0;
            a_reg <= '0;
            b_reg <= '0;
            x_reg <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            s_reg <= s_nxt;
            a_reg <= a_nxt;
            b_reg <= b_nxt;
            x_reg <= x_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign product = {a_reg, b_reg};
    assign x_sign  = x_reg;

endmodule

// File: tb/tb_signed_mult_seq.sv
// Directed bench for signed_mult_seq: 8-bit and 16-bit instances, hand-computed products
// and latencies (latency expectations follow SMULT_SKIP_ZERO_EN when it is defined).
module tb_signed_mult_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start8;
    logic [7:0]  mc8, mp8;
    logic        busy8, done8, xs8;
    logic [15:0] prod8;

    logic        start16;
    logic [15:0] mc16, mp16;
    logic        busy16, done16, xs16;
    logic [31:0] prod16;

    int total = 0;
    int bad   = 0;

    signed_mult_seq #(.WIDTH(8)) dut8 (
        .Clk(clk), .Reset(rst), .start(start8),
        .multiplicand(mc8), .multiplier(mp8),
        .busy(busy8), .done(done8), .product(prod8), .x_sign(xs8)
    );

    signed_mult_seq #(.WIDTH(16)) dut16 (
        .Clk(clk), .Reset(rst), .start(start16),
        .multiplicand(mc16), .multiplier(mp16),
        .busy(busy16), .done(done16), .product(prod16), .x_sign(xs16)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Edges from acceptance to the edge that samples done high.
    function automatic int lat8(input logic [7:0] m);
`ifdef SMULT_SKIP_ZERO_EN
        return 8 + $countones(m) + 1;
`else
        return 17;
`endif
    endfunction

    function automatic int lat16(input logic [15:0] m);
`ifdef SMULT_SKIP_ZERO_EN
        return 16 + $countones(m) + 1;
`else
        return 33;
`endif
    endfunction

    // Counts negedges until done8 is seen high; the first negedge after edge t counts as 1.
    task automatic wait_done8(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done8 && n < 100);
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp, input string tag);
        int n;
        @(negedge clk);
        mc8 = a; mp8 = b; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        check({tag, "_busy"}, busy8, 1'b1);
        wait_done8(n);
        check({tag, "_lat"}, n, lat8(b));
        check({tag, "_prod"}, prod8, exp);
        check({tag, "_xs"}, xs8, exp[15]);
        @(negedge clk);
        check({tag, "_done_pulse"}, done8, 1'b0);
        check({tag, "_prod_hold"}, prod8, exp);
    endtask

    initial begin
        int n, n2;
        bit seen;
        rst = 1'b1;
        start8 = 1'b0; mc8 = '0; mp8 = '0;
        start16 = 1'b0; mc16 = '0; mp16 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy8, 1'b0);
        check("rst_done", done8, 1'b0);
        check("rst_prod", prod8, 16'h0000);
        check("rst_xs", xs8, 1'b0);
        check("rst_prod16", prod16, 32'h0);
        rst = 1'b0;

        run8(8'd7,   8'hFD, 16'hFFEB, "7xm3");
        run8(8'h80,  8'h80, 16'h4000, "m128xm128");
        run8(8'd127, 8'd127, 16'h3F01, "127x127");
        run8(8'hFF,  8'hFF, 16'h0001, "m1xm1");
        run8(8'd0,   8'h80, 16'h0000, "0xm128");
        run8(8'd3,   8'h01, 16'h0003, "3x1");

        // start held high; operands change while busy
        @(negedge clk);
        mc8 = 8'd3; mp8 = 8'd4; start8 = 1'b1;
        @(posedge clk);
        #1 mc8 = 8'd9; mp8 = 8'd9;
        wait_done8(n);
        check("held_lat1", n, lat8(8'd4));
        check("held_prod1", prod8, 16'h000C);
        wait_done8(n2);
        check("held_lat2", n2, lat8(8'd9) + 1);
        check("held_prod2", prod8, 16'h0051);
        start8 = 1'b0;
        @(negedge clk);

        // reset during SHIFT of bit 3
        @(negedge clk);
        mc8 = 8'd100; mp8 = 8'hB3; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("midrst_busy_before", busy8, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("midrst_busy", busy8, 1'b0);
        check("midrst_prod", prod8, 16'h0000);
        check("midrst_xs", xs8, 1'b0);
        check("midrst_done", done8, 1'b0);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done8 || busy8) seen = 1'b1;
        end
        check("midrst_quiet", seen, 1'b0);
        run8(8'd5, 8'd5, 16'h0019, "5x5");

        // reset on the same edge as start: reset wins
        @(negedge clk);
        mc8 = 8'd6; mp8 = 8'd6; start8 = 1'b1; rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0; start8 = 1'b0;
        check("rststart_busy", busy8, 1'b0);
        check("rststart_prod", prod8, 16'h0000);
        @(negedge clk);
        check("rststart_busy2", busy8, 1'b0);

        // 16-bit instance
        @(negedge clk);
        mc16 = 16'h8000; mp16 = 16'h7FFF; start16 = 1'b1;
        @(posedge clk);
        #1 start16 = 1'b0;
        check("w16_busy", busy16, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done16 && n < 100);
        check("w16_lat", n, lat16(16'h7FFF));
        check("w16_prod", prod16, 32'hC0008000);
        check("w16_xs", xs16, 1'b1);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
